lsu_mem_initiator: RTL and testbench

- Load/store initiator between the CPU datapath and one read/write port of the byte-enable word RAM.
- Accepts one RV32 load or store per handshake and drives the RAM-side address, write data and per-byte write enables.
- Sign- or zero-extends load data.
- Splits an access that crosses a 32-bit word boundary into two RAM accesses, or faults on it, depending on MISALIGNED_SPLIT.

---
 rtl/lsu_mem_initiator.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// RV32 load/store initiator driving one byte-enable RAM port.
// Word-crossing accesses are either split into two RAM cycles or faulted.
module lsu_mem_initiator #(
  parameter int ADDR_WIDTH       = 14,
  parameter bit MISALIGNED_SPLIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wenable,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, FIRST, SECOND, RESP, FAULT} state_t;

  state_t                state, state_nxt;
  logic                  wr_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, part1, part2;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_cross(input logic [1:0] off, input logic [2:0] sz);
    return ({1'b0, off} + sz) > 3'd4;
  endfunction

  function automatic logic [3:0] bmask(input logic [2:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  // Request qualification (only meaningful in IDLE)
  logic accept, bad_f3, req_fault;
  assign accept    = req_valid && (state == IDLE);
  assign bad_f3    = req_write ? (req_funct3 > 3'd2)
                               : !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  assign req_fault = bad_f3 ||
                     (!MISALIGNED_SPLIT && is_cross(req_addr[1:0], size_of(req_funct3[1:0])));

  // Geometry of the latched access: n1 bytes in the first word, n2 in the next
  logic [2:0] size_q, n1, n2;
  logic       cross_q;
  logic [ADDR_WIDTH-3:0] word_nxt;
  assign size_q   = size_of(f3_q[1:0]);
  assign cross_q  = is_cross(addr_q[1:0], size_q);
  assign n1       = cross_q ? (3'd4 - {1'b0, addr_q[1:0]}) : size_q;
  assign n2       = size_q - n1;
  // Top word wraps to word 0 by plain truncation
  assign word_nxt = addr_q[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

  // Load result: merge the two halves, trim to size, then extend
  logic [31:0] raw, ext;
  always_comb begin
    raw = part1 | part2;
    case (size_q)
      3'd1:    raw = raw & 32'h0000_00FF;
      3'd2:    raw = raw & 32'h0000_FFFF;
      default: raw = raw;
    endcase
    case (f3_q)
      3'd0:    ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-state outputs; write enables are combinational so reset kills them at once
  always_comb begin
    state_nxt   = state;
    req_ready   = (state == IDLE);
    resp_valid  = 1'b0;
    resp_fault  = 1'b0;
    resp_rdata  = '0;
    mem_wenable = '0;
    case (state)
      IDLE:   if (accept) state_nxt = req_fault ? FAULT : FIRST;
      FIRST: begin
        if (wr_q) mem_wenable = bmask(n1);
        state_nxt = cross_q ? SECOND : RESP;
      end
      SECOND: begin
        if (wr_q) mem_wenable = bmask(n2);
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (!wr_q) resp_rdata = ext;
        state_nxt = IDLE;
      end
      FAULT: begin
        resp_valid = 1'b1;
        resp_fault = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, RAM address/data registers and load-part capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      part1     <= '0;
      part2     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          wr_q    <= req_write;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          part1   <= '0;
          part2   <= '0;
          // Faulting requests never touch the RAM-side registers
          if (!req_fault) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
          end
        end
        FIRST: begin
          part1 <= mem_rdata;
          if (cross_q) begin
            mem_addr  <= {word_nxt, 2'b00};
            mem_wdata <= wdata_q >> {n1, 3'b000};
          end
        end
        SECOND: part2 <= mem_rdata << {n1, 3'b000};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench: byte RAM model on the split DUT, plus a no-split DUT for the misaligned fault.
module tb_lsu_mem_initiator;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;

  logic          ready0, rv0, rf0, ready1, rv1, rf1;
  logic [31:0]   rdata0, rdata1, wdata0, wdata1, ram_rdata;
  logic [AW-1:0] addr0, addr1;
  logic [3:0]    wen0, wen1;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.ADDR_WIDTH(AW), .MISALIGNED_SPLIT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(ready0),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_fault(rf0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_wenable(wen0), .mem_rdata(ram_rdata));

  lsu_mem_initiator #(.ADDR_WIDTH(AW), .MISALIGNED_SPLIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(ready1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rdata1), .resp_fault(rf1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_wenable(wen1), .mem_rdata(32'h0));

  // Byte RAM model
  logic [7:0] ram [0:(1<<AW)-1];

  always_comb begin
    ram_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (int'(addr0[1:0]) + i <= 3) ram_rdata[8*i +: 8] = ram[int'(addr0) + i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wen0[i]) ram[int'(addr0) + i] <= wdata0[8*i +: 8];
  end

  // Selected-DUT views for the transaction task
  logic          dsel = 1'b0;
  logic          rv_s, rf_s;
  logic [31:0]   rdata_s, wdata_s;
  logic [AW-1:0] addr_s;
  logic [3:0]    wen_s;
  assign rv_s    = dsel ? rv1    : rv0;
  assign rf_s    = dsel ? rf1    : rf0;
  assign rdata_s = dsel ? rdata1 : rdata0;
  assign wdata_s = dsel ? wdata1 : wdata0;
  assign addr_s  = dsel ? addr1  : addr0;
  assign wen_s   = dsel ? wen1   : wen0;

  int          n_chk = 0, n_fail = 0;
  int          nw, rk, cnt;
  logic [31:0] rr;
  logic        rf;
  logic [3:0]    lw_wen   [4];
  logic [AW-1:0] lw_addr  [4];
  logic [31:0]   lw_wdata [4];
  logic [AW-1:0] a_log    [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request; logs RAM activity per cycle after acceptance and checks latency
  task automatic xact(input bit sel, input bit wr, input logic [2:0] f3, input logic [AW-1:0] a,
                      input logic [31:0] wd, input int lat, input string tag);
    dsel = sel;
    @(negedge clk);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0; req_valid1 = 1'b0;
    nw = 0; rk = 0; rr = '0; rf = 1'b0;
    for (int k = 1; k <= 8 && rk == 0; k++) begin
      @(negedge clk);
      if (k < 4) a_log[k] = addr_s;
      if (wen_s != 4'b0 && nw < 4) begin
        lw_wen[nw] = wen_s; lw_addr[nw] = addr_s; lw_wdata[nw] = wdata_s; nw++;
      end
      if (rv_s) begin rk = k; rr = rdata_s; rf = rf_s; end
    end
    chk({tag, ".lat"}, rk, lat);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.ready", ready0, 1);
    chk("rst.resp_valid", rv0, 0);
    chk("rst.resp_fault", rf0, 0);
    chk("rst.rdata", rdata0, 0);
    chk("rst.wen", wen0, 0);
    chk("rst.addr", addr0, 0);
    chk("rst.wdata", wdata0, 0);
    @(negedge clk); rst = 1'b0;

    // Aligned word store/load
    xact(0, 1, 3'd2, 14'h10, 32'hDEADBEEF, 2, "sw10");
    chk("sw10.nw", nw, 1);
    chk("sw10.wen", lw_wen[0], 4'b1111);
    chk("sw10.addr", lw_addr[0], 14'h10);
    chk("sw10.fault", rf, 0);
    chk("sw10.rdata", rr, 0);
    xact(0, 0, 3'd2, 14'h10, 0, 2, "lw10");
    chk("lw10.rdata", rr, 32'hDEADBEEF);
    chk("lw10.fault", rf, 0);
    chk("lw10.nw", nw, 0);

    // Byte store and signed/unsigned byte loads
    xact(0, 1, 3'd0, 14'h13, 32'hFFFFFF80, 2, "sb13");
    chk("sb13.nw", nw, 1);
    chk("sb13.wen", lw_wen[0], 4'b0001);
    chk("sb13.addr", lw_addr[0], 14'h13);
    xact(0, 0, 3'd0, 14'h13, 0, 2, "lb13");
    chk("lb13.rdata", rr, 32'hFFFFFF80);
    xact(0, 0, 3'd4, 14'h13, 0, 2, "lbu13");
    chk("lbu13.rdata", rr, 32'h00000080);

    // Split word load across 0x20/0x24
    xact(0, 1, 3'd2, 14'h20, 32'h44332211, 2, "sw20");
    xact(0, 1, 3'd2, 14'h24, 32'h88776655, 2, "sw24");
    xact(0, 0, 3'd2, 14'h22, 0, 3, "lw22");
    chk("lw22.addr1", a_log[1], 14'h22);
    chk("lw22.addr2", a_log[2], 14'h24);
    chk("lw22.rdata", rr, 32'h66554433);

    // Split halfword store and readback
    xact(0, 1, 3'd1, 14'h27, 32'h0000BBAA, 3, "sh27");
    chk("sh27.nw", nw, 2);
    chk("sh27.wen1", lw_wen[0], 4'b0001);
    chk("sh27.addr1", lw_addr[0], 14'h27);
    chk("sh27.wen2", lw_wen[1], 4'b0001);
    chk("sh27.wdata2", lw_wdata[1][7:0], 8'hBB);
    chk("sh27.addr2", lw_addr[1], 14'h28);
    xact(0, 0, 3'd5, 14'h27, 0, 3, "lhu27");
    chk("lhu27.rdata", rr, 32'h0000BBAA);
    xact(0, 0, 3'd1, 14'h27, 0, 3, "lh27");
    chk("lh27.rdata", rr, 32'hFFFFBBAA);

    // Faults
    xact(0, 0, 3'd3, 14'h10, 0, 1, "ldf3");
    chk("ldf3.fault", rf, 1);
    chk("ldf3.rdata", rr, 0);
    chk("ldf3.nw", nw, 0);
    xact(0, 1, 3'd4, 14'h10, 32'h12345678, 1, "stf4");
    chk("stf4.fault", rf, 1);
    chk("stf4.nw", nw, 0);
    xact(1, 1, 3'd2, 14'h21, 32'h12345678, 1, "nosplit");
    chk("nosplit.fault", rf, 1);
    chk("nosplit.nw", nw, 0);

    // Reset during the second half of a split store
    xact(0, 1, 3'd2, 14'h3C, 0, 2, "sw3c");
    xact(0, 1, 3'd2, 14'h40, 0, 2, "sw40");
    dsel = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'd2; req_addr = 14'h3E; req_wdata = 32'hCAFEF00D;
    req_valid0 = 1'b1;
    @(posedge clk);
    #1 req_valid0 = 1'b0;
    @(negedge clk);
    chk("rstsplit.wen1", wen0, 4'b0011);
    @(posedge clk);
    #2;
    chk("rstsplit.wen2", wen0, 4'b0011);
    chk("rstsplit.addr2", addr0, 14'h40);
    rst = 1'b1;
    #1;
    chk("rstsplit.wen_drop", wen0, 0);
    chk("rstsplit.ready_in_rst", ready0, 1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rv0) cnt++;
    end
    chk("rstsplit.no_resp", cnt, 0);
    chk("rstsplit.ready", ready0, 1);
    xact(0, 0, 3'd5, 14'h3E, 0, 2, "lhu3e");
    chk("lhu3e.rdata", rr, 32'h0000F00D);
    xact(0, 0, 3'd2, 14'h40, 0, 2, "lw40");
    chk("lw40.rdata", rr, 32'h0);

    // Top-word wrap to word 0
    xact(0, 1, 3'd2, 14'h0000, 32'h11223344, 2, "sw0");
    xact(0, 1, 3'd2, 14'h3FFC, 32'hAABBCCDD, 2, "swtop");
    xact(0, 0, 3'd2, 14'h3FFE, 0, 3, "lwwrap");
    chk("lwwrap.addr1", a_log[1], 14'h3FFE);
    chk("lwwrap.addr2", a_log[2], 14'h0000);
    chk("lwwrap.rdata", rr, 32'h3344AABB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
